// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - EX-stage multiply/divide sequencer owning the HI/LO registers
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [5:0]  op_sel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] opa_q, opb_q;
    logic        sign_q;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        issue, is_mul, is_div;

    // op_sel order: {mult, multu, div, divu, mthi, mtlo}; non-one-hot selects are no-ops
    assign issue  = (state == IDLE) && op_valid && !flush && $onehot(op_sel);
    assign is_mul = issue && (op_sel[5] || op_sel[4]);
    assign is_div = issue && (op_sel[3] || op_sel[2]);

    assign busy       = (state != IDLE);
    assign mul_ina    = is_mul ? src_a : opa_q;
    assign mul_inb    = is_mul ? src_b : opb_q;
    assign mul_signed = is_mul ? op_sel[5] : ((state == MUL_WAIT) && sign_q);
    assign div_opa    = opa_q;
    assign div_opb    = opb_q;
    assign div_signed = (state == DIV_WAIT) && sign_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        hi_nxt    = hi;
        lo_nxt    = lo;
        stallreq  = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    stallreq  = 1'b1;
                    cnt_nxt   = 4'(MUL_LAT - 1);
                    state_nxt = MUL_WAIT;
                end else if (is_div) begin
                    // divide by zero skips the divider and leaves HI/LO untouched
                    stallreq  = 1'b1;
                    state_nxt = (src_b == 32'd0) ? DONE : DIV_WAIT;
                end else if (issue && op_sel[1]) begin
                    hi_nxt = src_a;
                end else if (issue && op_sel[0]) begin
                    lo_nxt = src_a;
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (cnt_q == 4'd0) begin
                        {hi_nxt, lo_nxt} = mul_result;
                        state_nxt        = DONE;
                    end else begin
                        cnt_nxt = cnt_q - 4'd1;
                    end
                end
            end
            DIV_WAIT: begin
                if (flush) begin
                    div_annul = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stallreq  = 1'b1;
                    div_start = 1'b1;
                    if (div_ready) begin
                        {hi_nxt, lo_nxt} = div_result;
                        state_nxt        = DONE;
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt_q  <= 4'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            opa_q  <= 32'd0;
            opb_q  <= 32'd0;
            sign_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            if (is_mul || is_div) begin
                opa_q  <= src_a;
                opb_q  <= src_b;
                sign_q <= op_sel[5] || op_sel[3];
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [5:0]  op_sel;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        stallreq, busy;
    logic [31:0] hi, lo;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opa, div_opb;
    logic [63:0] div_result;
    logic        force_rdy;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] OP_MULT  = 6'b100000;
    localparam logic [5:0] OP_MULTU = 6'b010000;
    localparam logic [5:0] OP_DIV   = 6'b001000;
    localparam logic [5:0] OP_DIVU  = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_sel(op_sel),
        .src_a(src_a), .src_b(src_b), .flush(flush), .stallreq(stallreq),
        .busy(busy), .hi(hi), .lo(lo), .mul_signed(mul_signed),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa),
        .div_opb(div_opb), .div_annul(div_annul), .div_result(div_result),
        .div_ready(div_ready)
    );

    // two-stage multiplier model
    logic [63:0] prod, mr1, mr2;
    always_comb begin
        if (mul_signed)
            prod = 64'($signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb}));
        else
            prod = {32'd0, mul_ina} * {32'd0, mul_inb};
    end
    always_ff @(posedge clk) begin
        mr1 <= prod;
        mr2 <= mr1;
    end
    assign mul_result = mr2;

    // divider model: ready on the 5th cycle of div_start
    logic [2:0]  dcnt;
    logic [31:0] dq, dr;
    always_ff @(posedge clk) dcnt <= div_start ? dcnt + 3'd1 : 3'd0;
    assign div_ready = (div_start && dcnt == 3'd4) || force_rdy;
    always_comb begin
        dq = 32'd0;
        dr = 32'd0;
        if (div_opb != 32'd0) begin
            if (div_signed) begin
                dq = 32'($signed(div_opa) / $signed(div_opb));
                dr = 32'($signed(div_opa) % $signed(div_opb));
            end else begin
                dq = div_opa / div_opb;
                dr = div_opa % div_opb;
            end
        end
    end
    assign div_result = {dr, dq};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        op_valid = 1'b0;
        op_sel   = 6'b0;
        src_a    = 32'hDEADBEEF;
        src_b    = 32'h13579BDF;
        flush    = 1'b0;
        force_rdy = 1'b0;
    endtask

    // issue one op; return in the first cycle with stallreq low (DONE for stalling ops)
    task automatic run_op(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int starts, output int msg);
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = sel;
        src_a    = a;
        src_b    = b;
        #1;
        stalls = int'(stallreq);
        starts = 0;
        msg    = int'(mul_signed);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (!stallreq) break;
            stalls++;
            starts += int'(div_start);
            msg    |= int'(mul_signed);
        end
    endtask

    int st, ds, ms;

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #2;
        chk("reset_stall", 64'(stallreq), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_div", 64'({div_start, div_annul, div_signed}), 64'd0);
        chk("reset_mul", {mul_ina, mul_inb}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, st, ds, ms);
        chk("mult_stall", 64'(st), 64'd3);
        chk("mult_done_busy", 64'(busy), 64'd1);
        chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, st, ds, ms);
        chk("multu_stall", 64'(st), 64'd3);
        chk("multu_signed", 64'(ms), 64'd0);
        chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, st, ds, ms);
        chk("div_stall", 64'(st), 64'd6);
        chk("div_start_cycles", 64'(ds), 64'd5);
        chk("div_start_done", 64'(div_start), 64'd0);
        chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(OP_DIVU, 32'd7, 32'd2, st, ds, ms);
        chk("divu_stall", 64'(st), 64'd6);
        chk("divu_start_cycles", 64'(ds), 64'd5);
        chk("divu_hilo", {hi, lo}, 64'h00000001_00000003);

        run_op(OP_MTHI, 32'hAAAA0000, 32'd0, st, ds, ms);
        chk("mthi_nostall", 64'(st), 64'd0);
        run_op(OP_MTLO, 32'h00005555, 32'd0, st, ds, ms);
        chk("preload_hilo", {hi, lo}, 64'hAAAA0000_00005555);

        run_op(OP_DIV, 32'd9, 32'd0, st, ds, ms);
        chk("div0_stall", 64'(st), 64'd1);
        chk("div0_start", 64'(ds), 64'd0);
        chk("div0_done_busy", 64'(busy), 64'd1);
        chk("div0_hilo", {hi, lo}, 64'hAAAA0000_00005555);

        // flush on the 3rd DIV_WAIT cycle with a simultaneous div_ready
        @(negedge clk);
        op_valid = 1'b1; op_sel = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk); idle_inputs();
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; force_rdy = 1'b1;
        #1;
        chk("flush_annul", 64'(div_annul), 64'd1);
        chk("flush_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush_idle", 64'(busy), 64'd0);
        chk("flush_annul_once", 64'(div_annul), 64'd0);
        chk("flush_hilo", {hi, lo}, 64'hAAAA0000_00005555);

        // back-to-back moves
        @(negedge clk);
        op_valid = 1'b1; op_sel = OP_MTHI; src_a = 32'h1234;
        #1;
        chk("mthi_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        op_sel = OP_MTLO; src_a = 32'h5678;
        #1;
        chk("mthi_visible", 64'(hi), 64'h1234);
        chk("mtlo_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("moves_hilo", {hi, lo}, 64'h00001234_00005678);

        // invalid (non-one-hot) op_sel is a no-op
        @(negedge clk);
        op_valid = 1'b1; op_sel = 6'b100010; src_a = 32'h0F0F; src_b = 32'd3;
        #1;
        chk("bad_sel_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("bad_sel_state", {31'd0, busy, hi}, 64'h00000000_00001234);

        // asynchronous reset in MUL_WAIT
        @(negedge clk);
        op_valid = 1'b1; op_sel = OP_MULT; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mulwait_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("areset_hilo", {hi, lo}, 64'd0);
        chk("areset_stall_busy", 64'({stallreq, busy}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
